bmp_copy_seq: RTL and testbench
===============================

// Module: bmp_copy_seq
// PURPOSE
//   Sequencer for the BMP ROM->RAM byte-copy datapath. On a start pulse it streams a BMP file
//   from the image ROM into working RAM at 1 byte/cycle and parses the 54-byte header on the fly.
//   It validates the 'BM' signature and the file size, and exports width/height/offset/bpp to
//   downstream image-processing blocks. Sits between the testbench/top start logic and the ROM/RAM models.
// PARAMETERS
//   BYTE_WIDTH  8        data width of ROM/RAM (from DEFINE.vh `BYTE_WIDTH)
//   ADDR_WIDTH  20       ROM/RAM address width (from DEFINE.vh `ADDR_WIDTH)
//   MAX_SIZE    786486   largest legal file size in bytes; larger -> error
// PORTS
//   clk         in   1           rising-edge clock
//   rst_n       in   1           asynchronous active-low reset
//   in_valid    in   1           start pulse; sampled only in IDLE/DONE/ERR
//   ROM_Q       in   BYTE_WIDTH  ROM read data, valid 1 cycle after ROM_valid
//   ROM_valid   out  1           ROM read strobe
//   ROM_addr    out  ADDR_WIDTH  ROM read address
//   RAM_valid   out  1           RAM write strobe
//   RAM_D       out  BYTE_WIDTH  RAM write data
//   RAM_addr    out  ADDR_WIDTH  RAM write address
//   busy        out  1           high from start until DONE/ERR
//   done        out  1           level; high in DONE until next start
//   error       out  1           level; high in ERR until next start
//   file_size   out  32          bytes 2..5, little-endian
//   pix_offset  out  32          bytes 10..13
//   img_width   out  32          bytes 18..21
//   img_height  out  32          bytes 22..25
//   img_bpp     out  16          bytes 28..29
// BEHAVIOUR
//   - Reset: state IDLE; all outputs and header registers 0. Reset mid-copy aborts immediately, no flush.
//   - FSM: IDLE -(in_valid)-> HDR -(byte 53 issued)-> PIX -(last byte written)-> DONE; any -(check fail)-> ERR.
//     DONE/ERR -(in_valid)-> HDR, after clearing done/error/header regs and zeroing ROM_addr/RAM_addr.
//   - Read issue: ROM_valid=1 every cycle in HDR/PIX; ROM_addr starts at 0 and increments after each issue.
//   - Write: ROM_Q registered; RAM_valid asserts the cycle after each returned byte. RAM_D = that byte.
//     RAM_addr = byte index. Start-to-first-write latency = 2 cycles; steady throughput = 1 byte/cycle.
//   - Field capture: a byte-index counter on the return path loads each field byte into its position
//     (little-endian) as it arrives.
//   - Signature: byte0 must be 8'h42, byte1 8'h4D. On a mismatch when that byte arrives, the bad byte is
//     not written, reads stop that cycle, in-flight returns are discarded, and the FSM enters ERR.
//   - Size check on byte 5 arrival: file_size < 54 or > MAX_SIZE -> ERR (same abort rule).
//   - PIX issues reads up to file_size-1 exactly; ROM_addr stops there. done asserts the cycle after the
//     write of byte file_size-1. Total cycles from start to done = file_size + 2.
//   - in_valid while busy: ignored.
//   - ADDR_WIDTH arithmetic is unsigned. ROM_addr never wraps, because MAX_SIZE < 2**ADDR_WIDTH
//     (elaboration check).
// CONFIGURATION
//   `HEADER_STRIP_EN defined: header bytes 0..pix_offset-1 are read and parsed but not written.
//     Pixel byte k (k = ROM index - pix_offset) is written to RAM_addr k.
//     Additional error: pix_offset < 54 or >= file_size -> ERR on arrival of byte 13.
//   Undefined: the whole file is copied 1:1 (RAM_addr = ROM index); pix_offset is only reported.
// STRUCTURE
//   - Shared DEFINE.vh holds: `BYTE_WIDTH, `ADDR_WIDTH, `BMP_HDR_SIZE (54), signature bytes,
//     field byte offsets (2, 10, 18, 22, 28), and the state encodings.
//   - One sub-module, bmp_hdr_parser: byte-index + data in; field registers, sig_err, size_err out.
//   - bmp_copy_seq keeps the FSM, address counters and write pipe.
// TESTING
//   1. Valid 24bpp 4x2 file (size 78, offset 54) -> 78 RAM writes with addr 0..77 matching ROM;
//      width=4, height=2, bpp=24; done at cycle 80.
//   2. byte0=8'h41 -> no RAM writes, error=1 by cycle 3, ROM_valid low from then on, done=0.
//   3. file_size field = 40 -> error after byte 5 arrives; RAM writes only for bytes 0..4.
//   4. rst_n low at byte 30 of a 78-byte copy -> all outputs 0 the same cycle;
//      restart -> full copy from addr 0.
//   5. in_valid pulsed at cycles 10 and 40 during a copy -> ignored; one copy; done at cycle 80.
//   6. HEADER_STRIP_EN, offset 54, size 78 -> 24 writes, RAM_addr 0..23 = ROM 54..77;
//      offset 80 -> error.

Source files
------------

// File: rtl/bmp_copy_seq_pkg.sv
// Shared constants and types for the BMP ROM->RAM copy sequencer.
// Holds the data/address widths, the BMP header layout and the FSM state encoding.
package bmp_copy_seq_pkg;

    localparam int BYTE_WIDTH = 8;
    localparam int ADDR_WIDTH = 20;
    localparam int HDR_SIZE   = 54;

    localparam int OFS_SIZE   = 2;
    localparam int OFS_OFFSET = 10;
    localparam int OFS_WIDTH  = 18;
    localparam int OFS_HEIGHT = 22;
    localparam int OFS_BPP    = 28;

    typedef logic [BYTE_WIDTH-1:0] byte_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam byte_t SIG0 = 8'h42;
    localparam byte_t SIG1 = 8'h4D;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_PIX  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/bmp_copy_seq_if.sv
// Start/ROM/RAM/status bundle of the BMP copy sequencer.
// master = the sequencer, slave = start logic plus ROM/RAM models.
interface bmp_copy_seq_if;
    import bmp_copy_seq_pkg::*;

    logic        in_valid;
    byte_t       ROM_Q;
    logic        ROM_valid;
    addr_t       ROM_addr;
    logic        RAM_valid;
    byte_t       RAM_D;
    addr_t       RAM_addr;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] file_size;
    logic [31:0] pix_offset;
    logic [31:0] img_width;
    logic [31:0] img_height;
    logic [15:0] img_bpp;

    modport master (
        input  in_valid, ROM_Q,
        output ROM_valid, ROM_addr, RAM_valid, RAM_D, RAM_addr,
        output busy, done, error,
        output file_size, pix_offset, img_width, img_height, img_bpp
    );

    modport slave (
        output in_valid, ROM_Q,
        input  ROM_valid, ROM_addr, RAM_valid, RAM_D, RAM_addr,
        input  busy, done, error,
        input  file_size, pix_offset, img_width, img_height, img_bpp
    );

endinterface

// File: rtl/bmp_copy_seq_hdr_parser.sv
// BMP header field capture on the ROM return path, plus signature/size/offset checks.
// Checks are combinational on the arriving byte so the sequencer can abort on that edge.
module bmp_copy_seq_hdr_parser
    import bmp_copy_seq_pkg::*;
#(
    parameter int unsigned MAX_SIZE = 786486
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_valid,
    input  addr_t       i_idx,
    input  byte_t       i_data,
    output logic [31:0] o_file_size,
    output logic [31:0] o_pix_offset,
    output logic [31:0] o_img_width,
    output logic [31:0] o_img_height,
    output logic [15:0] o_img_bpp,
    output logic        o_sig_err,
    output logic        o_size_err,
    output logic        o_off_err
);

    localparam logic [31:0] MAX_SIZE_W = 32'(MAX_SIZE);
    localparam logic [31:0] HDR_SIZE_W = 32'(HDR_SIZE);

    logic [31:0] r_file_size;
    logic [31:0] r_pix_offset;
    logic [31:0] r_img_width;
    logic [31:0] r_img_height;
    logic [15:0] r_img_bpp;
    logic [31:0] w_size_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_file_size  <= '0;
            r_pix_offset <= '0;
            r_img_width  <= '0;
            r_img_height <= '0;
            r_img_bpp    <= '0;
        end else if (i_clr) begin
            r_file_size  <= '0;
            r_pix_offset <= '0;
            r_img_width  <= '0;
            r_img_height <= '0;
            r_img_bpp    <= '0;
        end else if (i_valid) begin
            // Little-endian: byte lane n of each field sits at field offset + n.
            for (int lane = 0; lane < 4; lane++) begin
                if (i_idx == addr_t'(OFS_SIZE + lane))   r_file_size[lane*8 +: 8]  <= i_data;
                if (i_idx == addr_t'(OFS_OFFSET + lane)) r_pix_offset[lane*8 +: 8] <= i_data;
                if (i_idx == addr_t'(OFS_WIDTH + lane))  r_img_width[lane*8 +: 8]  <= i_data;
                if (i_idx == addr_t'(OFS_HEIGHT + lane)) r_img_height[lane*8 +: 8] <= i_data;
            end
            for (int lane = 0; lane < 2; lane++) begin
                if (i_idx == addr_t'(OFS_BPP + lane))    r_img_bpp[lane*8 +: 8]    <= i_data;
            end
        end
    end

    assign w_size_val = {i_data, r_file_size[23:0]};

    assign o_sig_err  = i_valid && (((i_idx == addr_t'(0)) && (i_data != SIG0)) ||
                                    ((i_idx == addr_t'(1)) && (i_data != SIG1)));
    assign o_size_err = i_valid && (i_idx == addr_t'(OFS_SIZE + 3)) &&
                        ((w_size_val < HDR_SIZE_W) || (w_size_val > MAX_SIZE_W));

`ifdef HEADER_STRIP_EN
    logic [31:0] w_off_val;
    assign w_off_val = {i_data, r_pix_offset[23:0]};
    assign o_off_err = i_valid && (i_idx == addr_t'(OFS_OFFSET + 3)) &&
                       ((w_off_val < HDR_SIZE_W) || (w_off_val >= r_file_size));
`else
    assign o_off_err = 1'b0;
`endif

    assign o_file_size  = r_file_size;
    assign o_pix_offset = r_pix_offset;
    assign o_img_width  = r_img_width;
    assign o_img_height = r_img_height;
    assign o_img_bpp    = r_img_bpp;

endmodule

// File: rtl/bmp_copy_seq.sv
// BMP ROM->RAM copy sequencer: 1 byte/cycle stream with on-the-fly header parse and checks.
// Optional HEADER_STRIP_EN: header bytes are parsed but not written; pixels land at RAM_addr 0.
//
//   state  | meaning
//   IDLE   | after reset, waiting for in_valid
//   HDR    | issuing header reads 0..53, checks active on returns
//   PIX    | issuing reads up to file_size-1, draining returns
//   DONE   | copy complete, done high until next start
//   ERR    | check failed, reads stopped, error high until next start
module bmp_copy_seq
    import bmp_copy_seq_pkg::*;
#(
    parameter int unsigned MAX_SIZE = 786486
) (
    input  logic           clk,
    input  logic           rst_n,
    bmp_copy_seq_if.master bus
);

    localparam addr_t HDR_LAST = addr_t'(HDR_SIZE - 1);

    if (64'(MAX_SIZE) >= (64'd1 << ADDR_WIDTH)) begin : g_size_chk
        $error("MAX_SIZE does not fit in ROM_addr");
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rom_valid;
    addr_t       r_rom_addr;
    logic        r_ret_valid;
    addr_t       r_ret_idx;
    logic        r_ram_valid;
    byte_t       r_ram_d;
    addr_t       r_ram_addr;
    logic        r_last_wr;

    logic        w_start;
    logic        w_abort;
    logic        w_sig_err;
    logic        w_size_err;
    logic        w_off_err;
    logic [31:0] w_file_size;
    logic [31:0] w_pix_offset;
    addr_t       w_last_addr;
    logic        w_issue_last;
    logic        w_ret_last;
    logic        w_wr_en;
    addr_t       w_wr_addr;

    bmp_copy_seq_hdr_parser #(.MAX_SIZE(MAX_SIZE)) u_hdr_parser (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_start),
        .i_valid      (r_ret_valid),
        .i_idx        (r_ret_idx),
        .i_data       (bus.ROM_Q),
        .o_file_size  (w_file_size),
        .o_pix_offset (w_pix_offset),
        .o_img_width  (bus.img_width),
        .o_img_height (bus.img_height),
        .o_img_bpp    (bus.img_bpp),
        .o_sig_err    (w_sig_err),
        .o_size_err   (w_size_err),
        .o_off_err    (w_off_err)
    );

    assign w_start     = bus.in_valid && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_abort     = w_sig_err || w_size_err || w_off_err;
    assign w_last_addr = w_file_size[ADDR_WIDTH-1:0] - addr_t'(1);

    // file_size is only complete once byte 5 is in; any index >= 53 is past that point.
    assign w_issue_last = r_rom_valid && (r_rom_addr >= HDR_LAST) && (r_rom_addr == w_last_addr);
    assign w_ret_last   = r_ret_valid && (r_ret_idx >= HDR_LAST) && (r_ret_idx == w_last_addr);

`ifdef HEADER_STRIP_EN
    assign w_wr_en   = r_ret_valid && !w_abort && (r_ret_idx >= addr_t'(HDR_SIZE)) &&
                       (r_ret_idx >= w_pix_offset[ADDR_WIDTH-1:0]);
    assign w_wr_addr = r_ret_idx - w_pix_offset[ADDR_WIDTH-1:0];
`else
    assign w_wr_en   = r_ret_valid && !w_abort;
    assign w_wr_addr = r_ret_idx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.in_valid) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                if (w_abort)                                         w_state_nxt = S_ERR;
                else if (r_rom_valid && (r_rom_addr == HDR_LAST))    w_state_nxt = S_PIX;
            end
            S_PIX: begin
                if (w_abort)        w_state_nxt = S_ERR;
                else if (r_last_wr) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_valid <= 1'b0;
            r_rom_addr  <= '0;
            r_ret_valid <= 1'b0;
            r_ret_idx   <= '0;
            r_ram_valid <= 1'b0;
            r_ram_d     <= '0;
            r_ram_addr  <= '0;
            r_last_wr   <= 1'b0;
        end else if (w_start) begin
            r_rom_valid <= 1'b1;
            r_rom_addr  <= '0;
            r_ret_valid <= 1'b0;
            r_ret_idx   <= '0;
            r_ram_valid <= 1'b0;
            r_ram_d     <= '0;
            r_ram_addr  <= '0;
            r_last_wr   <= 1'b0;
        end else begin
            // An abort also drops the read issued this cycle, so nothing stays in flight.
            r_ret_valid <= r_rom_valid && !w_abort;
            if (w_abort) begin
                r_rom_valid <= 1'b0;
            end else if (r_rom_valid) begin
                if (w_issue_last) r_rom_valid <= 1'b0;
                else              r_rom_addr  <= r_rom_addr + addr_t'(1);
            end
            if (r_ret_valid) r_ret_idx <= r_ret_idx + addr_t'(1);
            r_ram_valid <= w_wr_en;
            if (w_wr_en) begin
                r_ram_d    <= bus.ROM_Q;
                r_ram_addr <= w_wr_addr;
            end
            r_last_wr <= w_ret_last && !w_abort;
        end
    end

    assign bus.ROM_valid  = r_rom_valid;
    assign bus.ROM_addr   = r_rom_addr;
    assign bus.RAM_valid  = r_ram_valid;
    assign bus.RAM_D      = r_ram_d;
    assign bus.RAM_addr   = r_ram_addr;
    assign bus.busy       = (r_state == S_HDR) || (r_state == S_PIX);
    assign bus.done       = (r_state == S_DONE);
    assign bus.error      = (r_state == S_ERR);
    assign bus.file_size  = w_file_size;
    assign bus.pix_offset = w_pix_offset;

endmodule

// File: tb/tb_bmp_copy_seq.sv
// Directed bench for bmp_copy_seq: behavioural ROM, RAM write monitor, hand-computed expectations.
module tb_bmp_copy_seq;
    import bmp_copy_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bmp_copy_seq_if bus();

    bmp_copy_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    byte_t rom [0:1023];
    byte_t ram [0:1023];
    int    total = 0;
    int    bad = 0;
    int    wr_cnt = 0;
    int    addr_bad = 0;
    int    cyc;
    int    rv_cnt;
    int    fs_at_start;

`ifdef HEADER_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    always @(posedge clk) begin
        if (bus.ROM_valid) bus.ROM_Q <= rom[bus.ROM_addr[9:0]];
    end

    always @(negedge clk) begin
        if (bus.RAM_valid) begin
            ram[bus.RAM_addr[9:0]] = bus.RAM_D;
            if (int'(bus.RAM_addr) != wr_cnt) addr_bad++;
            wr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic build(input int size, input int offset, input int w, input int h, input int bpp);
        for (int i = 0; i < 1024; i++) begin
            rom[i] = byte_t'((i * 13 + 5) & 255);
            ram[i] = 8'h00;
        end
        for (int i = 0; i < 54; i++) rom[i] = 8'h00;
        rom[0] = 8'h42;
        rom[1] = 8'h4D;
        for (int k = 0; k < 4; k++) begin
            rom[2 + k]  = byte_t'((size >> (8 * k)) & 255);
            rom[10 + k] = byte_t'((offset >> (8 * k)) & 255);
            rom[14 + k] = byte_t'((40 >> (8 * k)) & 255);
            rom[18 + k] = byte_t'((w >> (8 * k)) & 255);
            rom[22 + k] = byte_t'((h >> (8 * k)) & 255);
        end
        rom[26] = 8'h01;
        rom[28] = byte_t'(bpp & 255);
        rom[29] = byte_t'((bpp >> 8) & 255);
        wr_cnt   = 0;
        addr_bad = 0;
    endtask

    // Start pulse, then count edges until done/error; in_valid re-pulsed at p1/p2 to test the busy guard.
    task automatic run(input int p1, input int p2, output int n);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        fs_at_start = int'(bus.file_size);
        n = 0;
        while (!(bus.done || bus.error) && n < 300) begin
            @(posedge clk);
            n++;
            #1;
            bus.in_valid = (n == p1) || (n == p2);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_data(input string tag, input int base, input int n);
        int mism;
        mism = 0;
        for (int k = 0; k < n; k++) if (ram[k] !== rom[base + k]) mism++;
        chk(tag, mism, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        build(78, 54, 4, 2, 24);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_status", {bus.busy, bus.done, bus.error, bus.ROM_valid, bus.RAM_valid}, 0);
        chk("rst_fields", bus.file_size | bus.img_width | 32'(bus.ROM_addr), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // valid 24bpp 4x2
        run(-1, -1, cyc);
        chk("t1_done_cyc", cyc, 80);
        chk("t1_done", bus.done, 1);
        chk("t1_error", bus.error, 0);
        chk("t1_busy", bus.busy, 0);
        chk("t1_wr_cnt", wr_cnt, STRIP ? 24 : 78);
        chk("t1_addr_seq", addr_bad, 0);
        chk_data("t1_data", STRIP ? 54 : 0, STRIP ? 24 : 78);
        chk("t1_width", bus.img_width, 4);
        chk("t1_height", bus.img_height, 2);
        chk("t1_bpp", bus.img_bpp, 24);
        chk("t1_fsize", bus.file_size, 78);
        chk("t1_offset", bus.pix_offset, 54);
        chk("t1_rom_addr", bus.ROM_addr, 77);

        // restart from DONE must clear header regs
        build(78, 80, 4, 2, 24);
        run(-1, -1, cyc);
        chk("t6_cleared", fs_at_start, 0);
        if (STRIP) begin
            chk("t6_err_cyc", cyc, 15);
            chk("t6_error", bus.error, 1);
            chk("t6_wr_cnt", wr_cnt, 0);
        end else begin
            chk("t6_done_cyc", cyc, 80);
            chk("t6_offset", bus.pix_offset, 80);
            chk("t6_wr_cnt", wr_cnt, 78);
        end

        // smallest legal file
        build(54, 54, 0, 0, 24);
        run(-1, -1, cyc);
        if (STRIP) begin
            chk("min_err_cyc", cyc, 15);
            chk("min_wr_cnt", wr_cnt, 0);
        end else begin
            chk("min_done_cyc", cyc, 56);
            chk("min_wr_cnt", wr_cnt, 54);
            chk_data("min_data", 0, 54);
            chk("min_rom_addr", bus.ROM_addr, 53);
        end

        // bad first signature byte
        build(78, 54, 4, 2, 24);
        rom[0] = 8'h41;
        run(-1, -1, cyc);
        chk("t2_err_cyc", cyc, 2);
        chk("t2_status", {bus.error, bus.done, bus.busy}, 3'b100);
        rv_cnt = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.ROM_valid) rv_cnt++;
        end
        chk("t2_rom_valid", rv_cnt, 0);
        chk("t2_wr_cnt", wr_cnt, 0);

        // bad second signature byte
        build(78, 54, 4, 2, 24);
        rom[1] = 8'h4E;
        run(-1, -1, cyc);
        chk("sig1_err_cyc", cyc, 3);
        chk("sig1_wr_cnt", wr_cnt, STRIP ? 0 : 1);

        // file_size below header size
        build(40, 54, 4, 2, 24);
        run(-1, -1, cyc);
        chk("t3_err_cyc", cyc, 7);
        chk("t3_error", bus.error, 1);
        chk("t3_wr_cnt", wr_cnt, STRIP ? 0 : 5);

        // file_size one above MAX_SIZE
        build(786487, 54, 4, 2, 24);
        run(-1, -1, cyc);
        chk("max_err_cyc", cyc, 7);

        // reset in the middle of a copy
        build(78, 54, 4, 2, 24);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (31) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_status", {bus.busy, bus.done, bus.error, bus.ROM_valid, bus.RAM_valid}, 0);
        chk("t4_rst_addr", 32'(bus.ROM_addr) | 32'(bus.RAM_addr) | 32'(bus.RAM_D), 0);
        chk("t4_rst_fields", bus.file_size | bus.pix_offset | bus.img_width | bus.img_height, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        build(78, 54, 4, 2, 24);
        run(-1, -1, cyc);
        chk("t4_done_cyc", cyc, 80);
        chk("t4_wr_cnt", wr_cnt, STRIP ? 24 : 78);
        chk("t4_addr_seq", addr_bad, 0);
        chk_data("t4_data", STRIP ? 54 : 0, STRIP ? 24 : 78);

        // start pulses while busy are ignored
        build(78, 54, 4, 2, 24);
        run(10, 40, cyc);
        chk("t5_done_cyc", cyc, 80);
        chk("t5_wr_cnt", wr_cnt, STRIP ? 24 : 78);
        chk("t5_addr_seq", addr_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
